// File: rtl/id_ex_operand_stage.sv
//==============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID-stage operand resolution with EX/MEM/WB bypassing, load-use
//            stall detection and the ID/EX pipeline register.
//            Optional macro HAZARD_STATS_EN adds stall_cnt/fwd_cnt counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RN    = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic [RN-1:0]    rs,
    input  logic [RN-1:0]    rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RN-1:0]    id_wn,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             flush,
    input  logic [WIDTH-1:0] ex_alu,
    input  logic [RN-1:0]    mem_wn,
    input  logic [RN-1:0]    wb_wn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic             wb_wreg,
    input  logic [WIDTH-1:0] mem_alu,
    input  logic [WIDTH-1:0] mem_mdata,
    input  logic [WIDTH-1:0] wb_d,
    output logic             stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [WIDTH-1:0] ex_imm,
    output logic [RN-1:0]    ex_wn,
    output logic             ex_wreg,
    output logic             ex_m2reg
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt
`endif
);

    localparam logic [RN-1:0] C_R0 = '0;

    logic             r_ex_valid;
    logic             r_ex_wreg;
    logic             r_ex_m2reg;
    logic [RN-1:0]    r_ex_wn;
    logic [WIDTH-1:0] r_ex_a;
    logic [WIDTH-1:0] r_ex_b;
    logic [WIDTH-1:0] r_ex_imm;

    logic             w_ex_hit_a, w_mem_hit_a, w_wb_hit_a, w_zero_a;
    logic             w_ex_hit_b, w_mem_hit_b, w_wb_hit_b, w_zero_b;
    logic [WIDTH-1:0] w_mem_fwd;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_stall;

    // A load in EX cannot forward yet; it is handled by the load-use stall.
    logic w_ex_fwd_ok;
    assign w_ex_fwd_ok = r_ex_valid & r_ex_wreg & ~r_ex_m2reg;
    assign w_mem_fwd   = mem_m2reg ? mem_mdata : mem_alu;

    assign w_zero_a    = (rs == C_R0);
    assign w_ex_hit_a  = w_ex_fwd_ok & (r_ex_wn == rs);
    assign w_mem_hit_a = mem_wreg & (mem_wn == rs);
    assign w_wb_hit_a  = wb_wreg & (wb_wn == rs);

    assign w_zero_b    = (rt == C_R0);
    assign w_ex_hit_b  = w_ex_fwd_ok & (r_ex_wn == rt);
    assign w_mem_hit_b = mem_wreg & (mem_wn == rt);
    assign w_wb_hit_b  = wb_wreg & (wb_wn == rt);

    always_comb begin
        w_op_a = qa;
        if (w_zero_a)         w_op_a = '0;
        else if (w_ex_hit_a)  w_op_a = ex_alu;
        else if (w_mem_hit_a) w_op_a = w_mem_fwd;
        else if (w_wb_hit_a)  w_op_a = wb_d;
    end

    always_comb begin
        w_op_b = qb;
        if (w_zero_b)         w_op_b = '0;
        else if (w_ex_hit_b)  w_op_b = ex_alu;
        else if (w_mem_hit_b) w_op_b = w_mem_fwd;
        else if (w_wb_hit_b)  w_op_b = wb_d;
    end

    assign w_stall = id_valid & ~flush & r_ex_valid & r_ex_wreg & r_ex_m2reg
                   & (r_ex_wn != C_R0)
                   & ((use_rs & (r_ex_wn == rs)) | (use_rt & (r_ex_wn == rt)));

    // Bubbles only clear control; data fields hold to avoid needless toggling.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ex_valid <= 1'b0;
            r_ex_wreg  <= 1'b0;
            r_ex_m2reg <= 1'b0;
            r_ex_wn    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_imm   <= '0;
        end else if (flush || w_stall) begin
            r_ex_valid <= 1'b0;
            r_ex_wreg  <= 1'b0;
            r_ex_m2reg <= 1'b0;
        end else begin
            r_ex_valid <= id_valid;
            r_ex_wreg  <= id_wreg & id_valid;
            r_ex_m2reg <= id_m2reg & id_valid;
            r_ex_wn    <= id_wn;
            r_ex_a     <= w_op_a;
            r_ex_b     <= w_op_b;
            r_ex_imm   <= id_imm;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic        w_fwd_used;

    assign w_fwd_used = (use_rs & ~w_zero_a & (w_ex_hit_a | w_mem_hit_a | w_wb_hit_a))
                      | (use_rt & ~w_zero_b & (w_ex_hit_b | w_mem_hit_b | w_wb_hit_b));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!flush && !w_stall && id_valid && w_fwd_used)
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

    assign stall    = w_stall;
    assign ex_valid = r_ex_valid;
    assign ex_wreg  = r_ex_wreg;
    assign ex_m2reg = r_ex_m2reg;
    assign ex_wn    = r_ex_wn;
    assign ex_a     = r_ex_a;
    assign ex_b     = r_ex_b;
    assign ex_imm   = r_ex_imm;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
//==============================================================================
// Module   : tb_id_ex_operand_stage
// Brief    : Directed self-checking bench for id_ex_operand_stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        id_valid, use_rs, use_rt, id_wreg, id_m2reg, flush;
    logic [4:0]  rs, rt, id_wn, mem_wn, wb_wn;
    logic [31:0] qa, qb, id_imm, ex_alu, mem_alu, mem_mdata, wb_d;
    logic        mem_wreg, mem_m2reg, wb_wreg;
    logic        stall, ex_valid, ex_wreg, ex_m2reg;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_wn;

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage #(.WIDTH(32), .RN(5)) dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .qa(qa), .qb(qb), .id_imm(id_imm),
        .id_wn(id_wn), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
        .ex_alu(ex_alu), .mem_wn(mem_wn), .wb_wn(wb_wn), .mem_wreg(mem_wreg),
        .mem_m2reg(mem_m2reg), .wb_wreg(wb_wreg), .mem_alu(mem_alu),
        .mem_mdata(mem_mdata), .wb_d(wb_d), .stall(stall), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_wn(ex_wn),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s, input logic [4:0] t,
                          input logic us, input logic ut, input logic [4:0] wn,
                          input logic wr, input logic ld, input logic [31:0] imm);
        id_valid = v;  rs = s;  rt = t;  use_rs = us;  use_rt = ut;
        id_wn = wn;  id_wreg = wr;  id_m2reg = ld;  id_imm = imm;
    endtask

    task automatic quiet_pipe();
        mem_wreg = 0; mem_m2reg = 0; mem_wn = 0; wb_wreg = 0; wb_wn = 0;
        flush = 0; ex_alu = 0; mem_alu = 0; mem_mdata = 0; wb_d = 0;
        qa = 0; qb = 0;
    endtask

    initial begin
        clrn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet_pipe();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", {31'd0, ex_valid}, 0);
        check("reset_ex_a", ex_a, 0);
        check("reset_stall", {31'd0, stall}, 0);
        clrn = 1'b1;

        // Producer of r3 into EX
        set_id(1, 1, 0, 1, 0, 5'd3, 1, 0, 32'h7);
        tick();
        check("cap_valid", {31'd0, ex_valid}, 1);
        check("cap_wn", {27'd0, ex_wn}, 3);
        check("cap_imm", ex_imm, 32'h7);

        // EX has priority over MEM/WB; rt=0 reads zero despite qb
        set_id(1, 3, 0, 1, 1, 5'd7, 1, 0, 0);
        ex_alu = 32'h11; mem_wreg = 1; mem_wn = 3; mem_alu = 32'h22;
        wb_wreg = 1; wb_wn = 3; wb_d = 32'h33; qa = 32'h44; qb = 32'h99;
        tick();
        check("ex_fwd_a", ex_a, 32'h11);
        check("r0_b", ex_b, 0);

        // EX holds r7 now; r3 comes from MEM ALU result
        set_id(1, 3, 3, 1, 1, 5'd8, 1, 0, 0);
        tick();
        check("mem_alu_a", ex_a, 32'h22);
        check("mem_alu_b", ex_b, 32'h22);

        mem_m2reg = 1; mem_mdata = 32'h66;
        set_id(1, 3, 9, 1, 1, 5'd8, 1, 0, 0);
        tick();
        check("mem_ld_a", ex_a, 32'h66);
        check("reg_b", ex_b, 32'h99);

        // WB bypass over stale regfile read
        quiet_pipe();
        wb_wreg = 1; wb_wn = 5; wb_d = 32'hDEADBEEF; qb = 32'h1234;
        set_id(1, 5, 9, 1, 1, 5'd8, 1, 0, 0);
        tick();
        check("wb_fwd_a", ex_a, 32'hDEADBEEF);
        check("no_fwd_b", ex_b, 32'h1234);

        // Load-use: lw r2 then add rt=2
        quiet_pipe();
        set_id(1, 0, 0, 0, 0, 5'd2, 1, 1, 0);
        tick();
        check("lw_m2reg", {31'd0, ex_m2reg}, 1);
        set_id(1, 4, 2, 1, 0, 5'd6, 1, 0, 0);
        #1 check("unused_no_stall", {31'd0, stall}, 0);
        use_rt = 1;
        #1 check("lu_stall", {31'd0, stall}, 1);
        tick();
        check("lu_bubble_valid", {31'd0, ex_valid}, 0);
        check("lu_bubble_wreg", {31'd0, ex_wreg}, 0);
        check("lu_stall_drop", {31'd0, stall}, 0);
        mem_wreg = 1; mem_m2reg = 1; mem_wn = 2; mem_mdata = 32'hCAFE0001;
        tick();
        check("lu_valid", {31'd0, ex_valid}, 1);
        check("lu_mdata_b", ex_b, 32'hCAFE0001);

        // Flush wins over a hazard
        quiet_pipe();
        set_id(1, 0, 0, 0, 0, 5'd2, 1, 1, 0);
        tick();
        set_id(1, 4, 2, 1, 1, 5'd6, 1, 0, 0);
        flush = 1;
        #1 check("flush_no_stall", {31'd0, stall}, 0);
        tick();
        check("flush_bubble", {31'd0, ex_valid}, 0);
        flush = 0;

        // r0 destinations: loads never stall, results never forward
        set_id(1, 0, 0, 0, 0, 5'd0, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 5'd6, 1, 0, 0);
        #1 check("r0_load_no_stall", {31'd0, stall}, 0);
        set_id(1, 1, 0, 1, 0, 5'd0, 1, 0, 0);
        tick();
        ex_alu = 32'h55; qa = 32'h0;
        set_id(1, 0, 0, 1, 0, 5'd6, 1, 0, 0);
        tick();
        check("r0_ex_a", ex_a, 0);

        // Invalid ID captures a bubble even if wreg set
        set_id(0, 1, 1, 1, 1, 5'd4, 1, 1, 0);
        tick();
        check("bubble_valid", {31'd0, ex_valid}, 0);
        check("bubble_wreg", {31'd0, ex_wreg}, 0);
        check("bubble_m2reg", {31'd0, ex_m2reg}, 0);

        // Async reset in the middle of a stall
        quiet_pipe();
        set_id(1, 0, 0, 0, 0, 5'd2, 1, 1, 32'h5);
        qa = 32'h77;
        tick();
        set_id(1, 2, 0, 1, 0, 5'd6, 1, 0, 0);
        #1 check("pre_rst_stall", {31'd0, stall}, 1);
        #1 clrn = 1'b0;
        #1;
        check("rst_ex_valid", {31'd0, ex_valid}, 0);
        check("rst_ex_m2reg", {31'd0, ex_m2reg}, 0);
        check("rst_ex_wn", {27'd0, ex_wn}, 0);
        check("rst_ex_imm", ex_imm, 0);
        check("rst_stall", {31'd0, stall}, 0);
        tick();
        clrn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
